display_scan_controller: RTL
============================

// Module: display_scan_controller
// PURPOSE
//   Time-multiplexes NUM_DIGITS BCD digits onto one shared 7-segment bus (seg_out) plus a one-hot
//   digit strobe (digit_sel). Sits between the BCD counter datapath and the pad outputs.
//   New values arrive through a valid/ready load port into a pending buffer. The displayed value
//   only changes at a frame boundary, so no frame ever mixes digits from two values.
//   Each digit slot has an inter-digit blanking gap to suppress ghosting.
// PARAMETERS
//   NUM_DIGITS    3     number of multiplexed digits (>=1)
//   PRESCALE      1000  clk cycles a digit is driven per slot (>=1)
//   BLANK_CYCLES  16    clk cycles of all-off gap before each digit (0 = no gap)
// PORTS
//   clk         in   1             system clock, all logic on rising edge
//   rst_n       in   1             asynchronous active-low reset
//   enable      in   1             1 = scan display; 0 = display dark, scanner idle
//   blank_lz    in   1             1 = blank leading zeros (digit 0 is never blanked)
//   load_valid  in   1             load request; load_bcd is valid while high
//   load_bcd    in   4*NUM_DIGITS  BCD value, nibble 0 = least significant digit
//   load_ready  out  1             1 = pending buffer empty, load accepted this cycle if valid
//   seg_out     out  7             segments {g,f,e,d,c,b,a}, active high
//   digit_sel   out  NUM_DIGITS    one-hot digit strobe, active high, bit 0 = LS digit
//   frame_done  out  1             1-cycle pulse on the last SHOW cycle of the last digit
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, active=0, pending empty, digit idx=0, counters=0.
//     Outputs: seg_out=0, digit_sel=0, frame_done=0, load_ready=1.
//   Load handshake: a transfer occurs when load_valid & load_ready. load_bcd goes to pending,
//     which becomes full, and load_ready=0 from the next cycle.
//     load_valid must stay asserted with stable data until accepted.
//   Pending->active transfer:
//     - IDLE: the cycle after acceptance.
//     - Scanning: on the frame_done cycle. If pending is empty, active is unchanged.
//     - load_ready returns to 1 the cycle after the transfer.
//     - A load accepted on the frame_done cycle stays in pending until the next boundary.
//   FSM (registered outputs):
//     IDLE  -> BLANK when enable=1 (-> SHOW if BLANK_CYCLES=0), with idx=0.
//     BLANK -> SHOW after BLANK_CYCLES cycles. digit_sel=0, seg_out=0.
//     SHOW  -> lasts PRESCALE cycles. digit_sel=1<<idx, seg_out=decode(active nibble idx).
//              At the end: idx wraps NUM_DIGITS-1 -> 0 (frame_done=1), else idx+1; then BLANK/SHOW.
//     any   -> IDLE the cycle after enable=0 is sampled. Outputs go 0, idx=0, counters clear,
//              pending is kept.
//   Latency: enable sampled 1 at edge N -> first BLANK cycle outputs visible after edge N.
//   Slot = BLANK_CYCLES+PRESCALE cycles; frame = NUM_DIGITS*slot; period is exact, no drift.
//   Decode: 0..9 -> 3F 06 5B 4F 66 6D 7D 07 7F 6F (hex, {g..a}); nibble A..F -> 40 (dash).
//   Leading-zero blank:
//     - Applies when blank_lz=1.
//     - Digit i>0 is blanked (seg_out=0, digit_sel still strobes) iff all nibbles >=i are 0.
//     - Evaluated on the active value only.
//   Counters sized $clog2 of their terminal count (min 1 bit) and wrap; no overflow paths.
// TESTING (NUM_DIGITS=3, PRESCALE=4, BLANK_CYCLES=2 unless stated)
//   1 Reset:
//     Assert rst_n=0 mid-SHOW, asynchronous to clk -> seg_out=0, digit_sel=0, frame_done=0
//     and load_ready=1 immediately. Release -> IDLE.
//   2 Basic scan:
//     Load 0x123 in IDLE, then enable=1 -> digit_sel 000x2, 001x4 (seg 4F), 000x2, 010x4 (5B),
//     000x2, 100x4 (06). frame_done=1 on cycle 18 only. The sequence repeats.
//   3 Leading zeros:
//     0x007 with blank_lz=1 -> digit0 seg 07, digits 1/2 seg 00 with digit_sel still strobing.
//     0x000 -> digit0 seg 3F. Same value with blank_lz=0 -> 3F on all digits.
//   4 Handshake:
//     Load 0x456 mid-frame -> load_ready=0. A second load 0x789 is held off (valid held high).
//     Active switches to 456 only after frame_done. 789 is then accepted and shows one frame later.
//   5 Enable drop:
//     enable=0 in the 3rd SHOW cycle of digit 1 -> outputs 0 the next cycle.
//     Re-enable -> restart at BLANK, digit 0, with no partial slot.
//   6 Invalid BCD and BLANK_CYCLES=0:
//     Nibble 0xA -> seg 40. With BLANK_CYCLES=0, digit_sel is never 0 while enabled
//     and the frame is 12 cycles.

Source files
------------

// File: rtl/display_scan_controller.sv
// Time-multiplexed 7-segment scanner with a single-entry pending buffer.
// A new value is only promoted to the displayed (active) value at a frame
// boundary, so a frame never mixes digits from two values.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | scanner stopped, outputs dark, pending promoted right away
// BLANK | inter-digit gap, all segments and strobes off
// SHOW  | digit idx strobed with its decoded segments
module display_scan_controller #(
  parameter int NUM_DIGITS   = 3,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  output logic                    load_ready,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CP = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CB = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int CW = (CP > CB) ? CP : CB;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] SHOW_LOAD  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   active, active_nxt, pending;
  logic            pend_full;
  logic            accept, xfer;
  logic [3:0]      nib;
  logic            lz_here, zero_run;
  logic [6:0]      seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic            fd_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign load_ready = ~pend_full;
  assign accept     = load_valid & ~pend_full;
  // frame_done is the registered flag of the current cycle, i.e. the frame's last SHOW cycle
  assign xfer       = (state == IDLE) | frame_done;
  assign active_nxt = (xfer & pend_full) ? pending : active;

  // Next-state logic: down-counter per phase, reload on terminal count
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          idx_nxt = '0;
          if (BLANK_CYCLES == 0) begin
            state_nxt = SHOW;
            cnt_nxt   = SHOW_LOAD;
          end else begin
            state_nxt = BLANK;
            cnt_nxt   = BLANK_LOAD;
          end
        end
        BLANK: begin
          if (cnt == '0) begin
            state_nxt = SHOW;
            cnt_nxt   = SHOW_LOAD;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            idx_nxt = (idx == LAST_IDX) ? '0 : idx + IW'(1);
            if (BLANK_CYCLES == 0) begin
              state_nxt = SHOW;
              cnt_nxt   = SHOW_LOAD;
            end else begin
              state_nxt = BLANK;
              cnt_nxt   = BLANK_LOAD;
            end
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output values for the coming cycle, derived from next state so outputs can be registered
  always_comb begin
    sel_nxt  = '0;
    seg_nxt  = '0;
    fd_nxt   = 1'b0;
    nib      = '0;
    lz_here  = 1'b0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (active_nxt[4*i +: 4] == 4'd0);
      if (idx_nxt == IW'(i)) begin
        nib     = active_nxt[4*i +: 4];
        lz_here = zero_run & (i != 0);
      end
    end
    if (state_nxt == SHOW) begin
      sel_nxt = NUM_DIGITS'(1) << idx_nxt;
      seg_nxt = (blank_lz & lz_here) ? 7'h00 : decode(nib);
      fd_nxt  = (cnt_nxt == '0) && (idx_nxt == LAST_IDX);
    end
  end

  // Scanner state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pending buffer fill on handshake, promotion to active at frame boundary or in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      pend_full <= 1'b0;
      active    <= '0;
    end else begin
      active <= active_nxt;
      if (accept) begin
        pending   <= load_bcd;
        pend_full <= 1'b1;
      end else if (xfer) begin
        pend_full <= 1'b0;
      end
    end
  end

  // Registered pad outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= '0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_nxt;
      digit_sel  <= sel_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule
